// File: rtl/cpu_types_pkg.sv
// Shared CPU cache types: instruction word, icache address view and frame layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int IIDX_W = 4;
  localparam int IBYT_W = 2;
  localparam int ITAG_W = WORD_W - IIDX_W - IBYT_W;

  typedef logic [WORD_W-1:0] word_t;

  // Byte address viewed as tag / index / byte-offset for the icache.
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [IBYT_W-1:0] bytoff;
  } icachef_t;

  // One direct-mapped frame.
  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Icache bus bundles: datapath-side request/response and memory-side fill port.
// Latency: n/a (wiring only).
// Backpressure: memory side stalls fills through iwait; datapath side stalls on ihit=0.
//
// datapath_cache_if: imemREN/imemaddr from datapath, ihit/imemload back.
// caches_if        : iREN/iaddr from cache, iwait/iload back from memory.
interface datapath_cache_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;

  modport master (output imemREN, output imemaddr, input ihit, input imemload);
  modport slave  (input imemREN, input imemaddr, output ihit, output imemload);
endinterface

interface caches_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport master (output iREN, output iaddr, input iwait, input iload);
  modport slave  (input iREN, input iaddr, output iwait, output iload);
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a single fill FSM.
// Latency: hit is combinational (same cycle); miss costs at least 2 cycles.
// Backpressure: ihit stays low while a fill waits on iwait; the fill address is held.
//
// Ports: CLK, nRST (async active-low);
//        dcif (datapath_cache_if.slave): imemREN, imemaddr -> ihit, imemload
//        cif  (caches_if.master)       : iREN, iaddr      <- iwait, iload
import cpu_types_pkg::*;

module icache #(
  parameter int NSETS = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  datapath_cache_if.slave  dcif,
  caches_if.master         cif
);

  localparam int IW = $clog2(NSETS);
  localparam int TW = WORD_W - IW - IBYT_W;

  // Frame storage as flops so reset can clear every frame at once.
  logic          r_valid [NSETS];
  logic [TW-1:0] r_tag   [NSETS];
  word_t         r_data  [NSETS];

  icache_state_t r_state;
  icache_state_t w_next;

  // Word address of the outstanding miss; byte offset is implicitly zero.
  logic [WORD_W-3:0] r_fill;

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [IW-1:0] w_fidx;
  logic [TW-1:0] w_ftag;
  logic          w_hit;
  logic          w_miss;
  logic          w_fill_we;

  assign w_idx  = dcif.imemaddr[IW+1:2];
  assign w_tag  = dcif.imemaddr[WORD_W-1:IW+2];
  assign w_fidx = r_fill[IW-1:0];
  assign w_ftag = r_fill[WORD_W-3:IW];

  assign w_hit  = dcif.imemREN && (r_state == IDLE) &&
                  r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss = dcif.imemREN && (r_state == IDLE) && !w_hit;

  always_comb begin
    w_next        = r_state;
    w_fill_we     = 1'b0;
    dcif.ihit     = 1'b0;
    dcif.imemload = '0;
    cif.iREN      = 1'b0;
    cif.iaddr     = '0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          dcif.ihit     = 1'b1;
          dcif.imemload = r_data[w_idx];
        end else if (w_miss) begin
          w_next = FETCH;
        end
      end
      FETCH: begin
        // Address changes on the datapath side are ignored until the fill lands.
        cif.iREN      = 1'b1;
        cif.iaddr     = {r_fill, 2'b00};
        dcif.imemload = cif.iload;
        if (!cif.iwait) begin
          w_fill_we = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fill <= '0;
    end else if (w_miss) begin
      r_fill <= dcif.imemaddr[WORD_W-1:2];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NSETS; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_data[i]  <= '0;
      end
    end else if (w_fill_we) begin
      r_valid[w_fidx] <= 1'b1;
      r_tag[w_fidx]   <= w_ftag;
      r_data[w_fidx]  <= cif.iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: per-cycle vector table through a scoreboard queue,
// plus a hand-written asynchronous reset in the middle of a fill.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_icache;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;

  datapath_cache_if dcif ();
  caches_if         cif ();

  icache #(.NSETS(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .dcif (dcif.slave),
    .cif  (cif.master)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        iwait;
    logic [31:0] iload;
    logic        e_ihit;
    logic [31:0] e_load;
    logic        chk_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
  } vec_t;

  typedef struct {
    string       name;
    logic        e_ihit;
    logic [31:0] e_load;
    logic        chk_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
  } exp_t;

  vec_t vecs[$];
  vec_t post[$];
  exp_t sb[$];
  int   nerr   = 0;
  int   nchecks = 0;

  function automatic vec_t V(logic ren, logic [31:0] addr, logic iwait, logic [31:0] iload,
                             logic eh, logic [31:0] el, logic cl, logic er, logic [31:0] ea);
    vec_t v;
    v.ren = ren; v.addr = addr; v.iwait = iwait; v.iload = iload;
    v.e_ihit = eh; v.e_load = el; v.chk_load = cl; v.e_iren = er; v.e_iaddr = ea;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_exp(string name, vec_t v);
    exp_t e;
    e.name = name; e.e_ihit = v.e_ihit; e.e_load = v.e_load;
    e.chk_load = v.chk_load; e.e_iren = v.e_iren; e.e_iaddr = v.e_iaddr;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      nchecks++;
      nerr++;
      $display("FAIL scoreboard_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".ihit"}, {31'b0, dcif.ihit}, {31'b0, e.e_ihit});
      chk({e.name, ".iREN"}, {31'b0, cif.iREN},  {31'b0, e.e_iren});
      chk({e.name, ".iaddr"}, cif.iaddr, e.e_iaddr);
      if (e.chk_load) chk({e.name, ".imemload"}, dcif.imemload, e.e_load);
    end
  endtask

  task automatic drive(vec_t v);
    dcif.imemREN  = v.ren;
    dcif.imemaddr = v.addr;
    cif.iwait     = v.iwait;
    cif.iload     = v.iload;
  endtask

  // One cycle: drive just after the edge, sample at the falling edge, advance.
  task automatic run(string tag, int i, vec_t v);
    drive(v);
    push_exp($sformatf("%s%0d", tag, i), v);
    @(negedge CLK);
    sample();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Main sequence: fill, offset-ignored hit, REN low, conflict misses, redirect during fill.
    vecs.push_back(V(1, 32'h40,  1, 32'h0,        0, 32'h0,        1, 0, 32'h0));  // c0 miss
    vecs.push_back(V(1, 32'h40,  1, 32'h0,        0, 32'h0,        0, 1, 32'h40)); // c1 wait
    vecs.push_back(V(1, 32'h40,  1, 32'h0,        0, 32'h0,        0, 1, 32'h40)); // c2 wait
    vecs.push_back(V(1, 32'h40,  1, 32'h0,        0, 32'h0,        0, 1, 32'h40)); // c3 wait
    vecs.push_back(V(1, 32'h40,  0, 32'h00A00093, 0, 32'h0,        0, 1, 32'h40)); // c4 fill
    vecs.push_back(V(1, 32'h40,  1, 32'h0,        1, 32'h00A00093, 1, 0, 32'h0));  // c5 hit
    vecs.push_back(V(1, 32'h42,  1, 32'h0,        1, 32'h00A00093, 1, 0, 32'h0));  // c6 offset
    vecs.push_back(V(0, 32'h40,  1, 32'h0,        0, 32'h0,        1, 0, 32'h0));  // c7 ren=0
    vecs.push_back(V(0, 32'h440, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0));  // c8 ren=0 no fill
    vecs.push_back(V(1, 32'h440, 1, 32'h0,        0, 32'h0,        1, 0, 32'h0));  // c9 conflict miss
    vecs.push_back(V(1, 32'h440, 0, 32'h12345678, 0, 32'h0,        0, 1, 32'h440));// c10 fill
    vecs.push_back(V(1, 32'h440, 1, 32'h0,        1, 32'h12345678, 1, 0, 32'h0));  // c11 hit
    vecs.push_back(V(1, 32'h40,  1, 32'h0,        0, 32'h0,        1, 0, 32'h0));  // c12 evicted
    vecs.push_back(V(1, 32'h40,  0, 32'h00A00093, 0, 32'h0,        0, 1, 32'h40)); // c13 refill
    vecs.push_back(V(1, 32'h40,  1, 32'h0,        1, 32'h00A00093, 1, 0, 32'h0));  // c14 hit
    vecs.push_back(V(1, 32'h80,  1, 32'h0,        0, 32'h0,        1, 0, 32'h0));  // c15 miss
    vecs.push_back(V(1, 32'h100, 1, 32'h0,        0, 32'h0,        0, 1, 32'h80)); // c16 redirect
    vecs.push_back(V(1, 32'h100, 0, 32'hCAFEF00D, 0, 32'h0,        0, 1, 32'h80)); // c17 fill 0x80
    vecs.push_back(V(1, 32'h80,  1, 32'h0,        1, 32'hCAFEF00D, 1, 0, 32'h0));  // c18 frame0=0x80
    vecs.push_back(V(1, 32'h100, 1, 32'h0,        0, 32'h0,        1, 0, 32'h0));  // c19 0x100 miss
    vecs.push_back(V(1, 32'h80,  0, 32'h0BADBEEF, 0, 32'h0,        0, 1, 32'h100));// c20 fill 0x100
    vecs.push_back(V(1, 32'h100, 1, 32'h0,        1, 32'h0BADBEEF, 1, 0, 32'h0));  // c21 hit
    vecs.push_back(V(1, 32'h14,  1, 32'h0,        0, 32'h0,        1, 0, 32'h0));  // c22 idx5 miss
    vecs.push_back(V(1, 32'h14,  0, 32'h00000055, 0, 32'h0,        0, 1, 32'h14)); // c23 fill
    vecs.push_back(V(1, 32'h14,  1, 32'h0,        1, 32'h00000055, 1, 0, 32'h0));  // c24 hit

    // After the mid-fill reset every frame must be invalid again.
    post.push_back(V(1, 32'h14,  1, 32'h0,        0, 32'h0,        1, 0, 32'h0));  // r0 miss
    post.push_back(V(1, 32'h14,  0, 32'h00000077, 0, 32'h0,        0, 1, 32'h14)); // r1 fill
    post.push_back(V(1, 32'h40,  1, 32'h0,        0, 32'h0,        1, 0, 32'h0));  // r2 0x40 miss
    post.push_back(V(1, 32'h14,  1, 32'h0,        0, 32'h0,        0, 1, 32'h40)); // r3 wait
    post.push_back(V(1, 32'h14,  0, 32'h00000099, 0, 32'h0,        0, 1, 32'h40)); // r4 fill
    post.push_back(V(1, 32'h14,  1, 32'h0,        1, 32'h00000077, 1, 0, 32'h0));  // r5 hit
    post.push_back(V(1, 32'h40,  1, 32'h0,        1, 32'h00000099, 1, 0, 32'h0));  // r6 hit

    // Reset state, with a request presented while reset is held.
    nRST = 1'b0;
    drive(V(0, 32'h0, 1, 32'h0, 0, 0, 0, 0, 0));
    #12;
    push_exp("rst_idle", V(0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0));
    sample();
    dcif.imemREN  = 1'b1;
    dcif.imemaddr = 32'h40;
    #1;
    push_exp("rst_req", V(0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0));
    sample();
    dcif.imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    foreach (vecs[i]) run("c", i, vecs[i]);

    // Reset asserted in the middle of a fill, between clock edges.
    run("mf_miss", 0, V(1, 32'h24, 1, 32'h0, 0, 32'h0, 1, 0, 32'h0));
    drive(V(1, 32'h24, 1, 32'h0, 0, 0, 0, 0, 0));
    push_exp("mf_fetch", V(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h24));
    @(negedge CLK);
    sample();
    #1;
    cif.iwait = 1'b0;
    cif.iload = 32'hDEADBEEF;
    nRST = 1'b0;
    #1;
    push_exp("mf_async", V(0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0));
    sample();
    @(posedge CLK);
    #1;
    push_exp("mf_held", V(0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0));
    sample();
    dcif.imemREN = 1'b0;
    cif.iwait    = 1'b1;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    foreach (post[i]) run("r", i, post[i]);

    if (sb.size() != 0) begin
      nchecks++;
      nerr++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
